conv1_sched: RTL and testbench
==============================

Name: conv1_sched

Overview:
- Sequencer for the first convolution layer.
- Walks the conv1 weight banks one at a time. For each bank it strobes the weight ROM load (start_flag), waits out the ROM read latency, then sweeps every output-pixel window position and hands each position to the conv1 datapath with a valid/ready handshake.
- Sits between the top-level layer controller (start/done) and the conv1 weight ROM plus the feature-window/MAC datapath.

Parameters:
- IMG_W, 28, input feature-map width in pixels.
- IMG_H, 28, input feature-map height in pixels.
- K, 3, square kernel size. OUT_W = IMG_W-K+1, OUT_H = IMG_H-K+1.
- BANKS, 3, number of weight banks; one 18-weight ROM image per bank, 54 weights total.
- ROM_LAT, 1, cycles from rom_start_flag to valid ROM data; legal values are 1..7.
- ROW_W, 5, width of the row coordinate; must hold OUT_H-1.
- COL_W, 5, width of the column coordinate; must hold OUT_W-1.
- BANK_W, 2, width of the bank index; must hold BANKS-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  run request; sampled only in IDLE.
- abort  in  1  synchronous cancel; returns to IDLE next cycle, no done.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last window of the last bank is accepted.
- bank_sel  out  BANK_W  current weight bank index presented to the ROM.
- rom_start_flag  out  1  one-cycle ROM load strobe.
- win_valid  out  1  window coordinate valid.
- win_ready  in  1  datapath accepts the window.
- win_row  out  ROW_W  output row of the current window.
- win_col  out  COL_W  output column of the current window.
- win_bank  out  BANK_W  bank tag carried with the window.
- win_last  out  1  current window is the last of its bank.
- layer_last  out  1  current window is the last of the layer.

Behaviour:
- Reset: rst is synchronous, active-high and has priority over everything, including abort and start. On reset:
  - state = IDLE;
  - busy, done, rom_start_flag, win_valid, win_last and layer_last = 0;
  - win_row, win_col, win_bank and bank_sel = 0.
- Reset mid-operation discards all progress; no done is produced.
- State machine: IDLE, LOAD, WAIT, SWEEP, DONE.
- IDLE:
  - start=1 moves to LOAD and clears bank, row and col to 0.
  - start is ignored in all other states.
- LOAD (1 cycle):
  - rom_start_flag=1 and bank_sel=bank.
  - Loads the wait counter with ROM_LAT-1, then moves to WAIT.
- WAIT:
  - Stays while the counter is nonzero, decrementing each cycle.
  - At 0 moves to SWEEP. WAIT therefore lasts exactly ROM_LAT cycles.
- SWEEP:
  - win_valid=1 on every SWEEP cycle.
  - win_row, win_col, win_bank, win_last and layer_last are registered outputs. They stay stable while win_valid=1 and win_ready=0.
  - On a handshake (win_valid and win_ready):
    - col increments;
    - at col=OUT_W-1, col wraps to 0 and row increments.
  - win_last = (row==OUT_H-1 && col==OUT_W-1). layer_last = win_last && bank==BANKS-1.
  - Handshake while win_last=1:
    - if bank<BANKS-1: bank increments, row and col clear, next state LOAD, and win_valid drops the next cycle;
    - otherwise: next state DONE.
- DONE (1 cycle): done=1, busy=1, then IDLE. busy drops in the IDLE cycle that follows.
- abort:
  - in any non-IDLE state, next state is IDLE and outputs take their reset values;
  - a handshake occurring in the same cycle as abort is not counted, and no done is produced.
- Throughput:
  - 1 window per cycle when win_ready=1.
  - Cycles per bank = 1 + ROM_LAT + OUT_W*OUT_H.
  - Total windows per run = BANKS*OUT_W*OUT_H.
- bank_sel holds its value between LOAD strobes so the ROM output stays associated with the sweep.
- Counters are unsigned and never exceed OUT_W-1, OUT_H-1 or BANKS-1; a combination that would exceed one is unreachable.

Decomposition:
- Shared package conv1_pkg:
  - state encoding (IDLE=0, LOAD=1, WAIT=2, SWEEP=3, DONE=4);
  - derived OUT_W/OUT_H constants;
  - bank and weight-count constants (18 weights per bank, 54 total).
- One natural sub-module: conv1_win_cnt, the row/col raster counter with advance, clear, wrap and last flags. The FSM and handshake stay in conv1_sched.

Test Plan:
1. Full run: IMG_W=IMG_H=5, K=3, BANKS=2, ROM_LAT=1, win_ready=1, start pulsed in cycle 0.
   - rom_start_flag is high in cycles 1 and 12, with bank_sel 0 then 1.
   - 9 windows per bank in raster order (0,0)..(2,2).
   - done is high in cycle 23 only.
2. Backpressure, same config: toggle win_ready 1,0,0,1 repeatedly.
   - Coordinates are held while ready=0.
   - Exactly 18 unique windows are delivered; no skips or duplicates.
   - win_last is high only on (2,2); layer_last only on bank 1 (2,2).
3. ROM_LAT=3: each LOAD is followed by exactly 3 WAIT cycles before win_valid rises.
   - The first window appears in cycle 5.
4. abort in cycle 8 (mid bank 0, ready=1).
   - Next cycle: IDLE, busy=0, win_valid=0, and no done ever.
   - A following start restarts from bank 0, (0,0).
5. rst high for one cycle mid-SWEEP of bank 1.
   - All outputs are 0 the next cycle.
   - start pulsed during a run is ignored; the run still finishes in 23 cycles.

Source files
------------

// File: rtl/conv1_pkg.sv
// conv1 layer sequencer shared types and constants.
// State encoding, default geometry, derived output size, weight counts.
package conv1_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WAIT  = 3'd2,
        S_SWEEP = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int IMG_W_DEF  = 28;
    localparam int IMG_H_DEF  = 28;
    localparam int K_DEF      = 3;
    localparam int OUT_W_DEF  = IMG_W_DEF - K_DEF + 1;
    localparam int OUT_H_DEF  = IMG_H_DEF - K_DEF + 1;
    localparam int BANKS_DEF  = 3;
    localparam int W_PER_BANK = 18;
    localparam int W_TOTAL    = W_PER_BANK * BANKS_DEF;

    // ROM_LAT is limited to 1..7, so a 3-bit wait counter suffices.
    localparam int LAT_W = 3;

    function automatic int out_dim(input int img, input int k);
        return img - k + 1;
    endfunction

endpackage

// File: rtl/conv1_win_cnt.sv
// Raster row/col counter for conv1 output windows.
// Ports: clk, rst, clr, adv in; row, col, last (final position) out.
module conv1_win_cnt #(
    parameter int OUT_W = 26,
    parameter int OUT_H = 26,
    parameter int ROW_W = 5,
    parameter int COL_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             adv,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             last
);

    logic col_end;
    logic row_end;

    assign col_end = (col == COL_W'(OUT_W - 1));
    assign row_end = (row == ROW_W'(OUT_H - 1));
    assign last    = col_end && row_end;

    // Advancing past the final position wraps to (0,0), ready for the next bank.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            row <= '0;
            col <= '0;
        end else if (adv) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv1_sched.sv
// conv1 sequencer: per bank, strobe ROM load, wait ROM latency, sweep windows.
// Ports: clk, rst, start, abort, win_ready in; busy, done, bank_sel, rom_start_flag, win_* out.
module conv1_sched
    import conv1_pkg::*;
#(
    parameter int IMG_W   = IMG_W_DEF,
    parameter int IMG_H   = IMG_H_DEF,
    parameter int K       = K_DEF,
    parameter int BANKS   = BANKS_DEF,
    parameter int ROM_LAT = 1,
    parameter int ROW_W   = 5,
    parameter int COL_W   = 5,
    parameter int BANK_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [BANK_W-1:0] bank_sel,
    output logic              rom_start_flag,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [ROW_W-1:0]  win_row,
    output logic [COL_W-1:0]  win_col,
    output logic [BANK_W-1:0] win_bank,
    output logic              win_last,
    output logic              layer_last
);

    localparam int OUT_W = out_dim(IMG_W, K);
    localparam int OUT_H = out_dim(IMG_H, K);

    state_t            state, state_n;
    logic [BANK_W-1:0] bank, bank_n;
    logic [LAT_W-1:0]  wcnt, wcnt_n;
    logic              cnt_clr, cnt_adv;
    logic              hs, last, last_bank;

    conv1_win_cnt #(
        .OUT_W (OUT_W),
        .OUT_H (OUT_H),
        .ROW_W (ROW_W),
        .COL_W (COL_W)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .adv  (cnt_adv),
        .row  (win_row),
        .col  (win_col),
        .last (last)
    );

    assign hs        = (state == S_SWEEP) && win_ready;
    assign last_bank = (bank == BANK_W'(BANKS - 1));

    assign busy           = (state != S_IDLE);
    assign done           = (state == S_DONE);
    assign rom_start_flag = (state == S_LOAD);
    assign win_valid      = (state == S_SWEEP);
    assign bank_sel       = bank;
    assign win_bank       = bank;
    assign win_last       = win_valid && last;
    assign layer_last     = win_valid && last && last_bank;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            bank  <= '0;
            wcnt  <= '0;
        end else begin
            state <= state_n;
            bank  <= bank_n;
            wcnt  <= wcnt_n;
        end
    end

    always_comb begin
        state_n = state;
        bank_n  = bank;
        wcnt_n  = wcnt;
        cnt_clr = 1'b0;
        cnt_adv = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_LOAD;
                    bank_n  = '0;
                    cnt_clr = 1'b1;
                end
            end
            S_LOAD: begin
                wcnt_n  = LAT_W'(ROM_LAT - 1);
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (wcnt == '0) state_n = S_SWEEP;
                else            wcnt_n  = wcnt - 1'b1;
            end
            S_SWEEP: begin
                if (hs) begin
                    // Counter wraps to (0,0) on the last window by itself.
                    cnt_adv = 1'b1;
                    if (last) begin
                        if (last_bank) begin
                            state_n = S_DONE;
                        end else begin
                            bank_n  = bank + 1'b1;
                            state_n = S_LOAD;
                        end
                    end
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        // Cancel drops the in-flight handshake and all progress.
        if (abort && state != S_IDLE) begin
            state_n = S_IDLE;
            bank_n  = '0;
            wcnt_n  = '0;
            cnt_adv = 1'b0;
            cnt_clr = 1'b1;
        end
    end

endmodule

// File: tb/tb_conv1_sched.sv
// Self-checking bench for conv1_sched against a window-list/timing model.
// Two DUTs: ROM_LAT=1 and ROM_LAT=3, selected through sel3.
module tb_conv1_sched;

    localparam int IW   = 5;
    localparam int IH   = 5;
    localparam int KK   = 3;
    localparam int NB   = 2;
    localparam int OW   = IW - KK + 1;
    localparam int OH   = IH - KK + 1;
    localparam int NWIN = OW * OH;

    typedef struct {
        int b;
        int r;
        int c;
    } win_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, abort, win_ready;
    bit   sel3;

    logic       a_busy, a_done, a_rom, a_valid, a_last, a_layer;
    logic [4:0] a_row, a_col;
    logic [1:0] a_bank, a_bsel;
    logic       b_busy, b_done, b_rom, b_valid, b_last, b_layer;
    logic [4:0] b_row, b_col;
    logic [1:0] b_bank, b_bsel;

    logic       o_busy, o_done, o_rom, o_valid, o_last, o_layer;
    logic [4:0] o_row, o_col;
    logic [1:0] o_bank, o_bsel;

    int   checks   = 0;
    int   failures = 0;
    win_t exp_q[$];

    conv1_sched #(
        .IMG_W(IW), .IMG_H(IH), .K(KK), .BANKS(NB), .ROM_LAT(1)
    ) dut (
        .clk(clk), .rst(rst), .start(start && !sel3), .abort(abort),
        .busy(a_busy), .done(a_done), .bank_sel(a_bsel),
        .rom_start_flag(a_rom), .win_valid(a_valid), .win_ready(win_ready),
        .win_row(a_row), .win_col(a_col), .win_bank(a_bank),
        .win_last(a_last), .layer_last(a_layer)
    );

    conv1_sched #(
        .IMG_W(IW), .IMG_H(IH), .K(KK), .BANKS(NB), .ROM_LAT(3)
    ) dut3 (
        .clk(clk), .rst(rst), .start(start && sel3), .abort(abort),
        .busy(b_busy), .done(b_done), .bank_sel(b_bsel),
        .rom_start_flag(b_rom), .win_valid(b_valid), .win_ready(win_ready),
        .win_row(b_row), .win_col(b_col), .win_bank(b_bank),
        .win_last(b_last), .layer_last(b_layer)
    );

    always_comb begin
        if (sel3) begin
            {o_busy, o_done, o_rom, o_valid, o_last, o_layer} =
                {b_busy, b_done, b_rom, b_valid, b_last, b_layer};
            {o_row, o_col, o_bank, o_bsel} = {b_row, b_col, b_bank, b_bsel};
        end else begin
            {o_busy, o_done, o_rom, o_valid, o_last, o_layer} =
                {a_busy, a_done, a_rom, a_valid, a_last, a_layer};
            {o_row, o_col, o_bank, o_bsel} = {a_row, a_col, a_bank, a_bsel};
        end
    end

    task automatic build_q();
        exp_q.delete();
        for (int b = 0; b < NB; b++)
            for (int r = 0; r < OH; r++)
                for (int c = 0; c < OW; c++)
                    exp_q.push_back('{b, r, c});
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; win_ready = 1'b0; sel3 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({a_busy, a_done, a_rom, a_valid, a_last, a_layer, a_row, a_col, a_bank, a_bsel,
             b_busy, b_done, b_rom, b_valid, b_last, b_layer, b_row, b_col, b_bank, b_bsel} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got a=%b/%h/%h b=%b/%h/%h required all zero",
                     {a_busy, a_done, a_rom, a_valid, a_last, a_layer}, {a_row, a_col}, {a_bank, a_bsel},
                     {b_busy, b_done, b_rom, b_valid, b_last, b_layer}, {b_row, b_col}, {b_bank, b_bsel});
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Expected timing from the per-bank period 1 + ROM_LAT + windows.
    task automatic test_timing(input int lat, input bit s3);
        int   p, ls, e_bank;
        logic e_rom, e_valid, e_busy, e_done, e_last, e_layer;
        win_t w;
        sel3 = s3; p = 1 + lat + NWIN;
        build_q();
        win_ready = 1'b1; start = 1'b1;
        for (int c = 0; c < NB * p + 5; c++) begin
            @(negedge clk);
            e_rom = 1'b0; e_valid = 1'b0; e_bank = 0;
            e_busy = (c >= 1 && c <= NB * p + 1);
            e_done = (c == NB * p + 1);
            for (int b = 0; b < NB; b++) begin
                ls = 1 + b * p;
                if (c == ls) begin e_rom = 1'b1; e_bank = b; end
                if (c >= ls + 1 + lat && c < ls + p) e_valid = 1'b1;
            end
            checks++;
            if ({o_rom, o_valid, o_busy, o_done} !== {e_rom, e_valid, e_busy, e_done}) begin
                failures++;
                $display("FAIL timing_lat%0d cyc %0d: rom/valid/busy/done got %b required %b",
                         lat, c, {o_rom, o_valid, o_busy, o_done}, {e_rom, e_valid, e_busy, e_done});
            end
            if (e_rom) begin
                checks++;
                if (o_bsel !== 2'(e_bank)) begin
                    failures++;
                    $display("FAIL bank_sel_lat%0d cyc %0d: got %0d required %0d", lat, c, o_bsel, e_bank);
                end
            end
            if (o_valid && exp_q.size() > 0) begin
                w = exp_q.pop_front();
                e_last  = (w.r == OH - 1 && w.c == OW - 1);
                e_layer = e_last && (w.b == NB - 1);
                checks++;
                if ({o_bank, o_row, o_col, o_last, o_layer} !==
                    {2'(w.b), 5'(w.r), 5'(w.c), e_last, e_layer}) begin
                    failures++;
                    $display("FAIL window_lat%0d cyc %0d: got b%0d(%0d,%0d) l%b/%b required b%0d(%0d,%0d) l%b/%b",
                             lat, c, o_bank, o_row, o_col, o_last, o_layer, w.b, w.r, w.c, e_last, e_layer);
                end
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL windows_left_lat%0d: got %0d remaining required 0", lat, exp_q.size());
        end
        sel3 = 1'b0;
    endtask

    // Ready either follows 1,0,0,1 or is random; every valid cycle must show the queue head.
    task automatic test_backpressure(input bit rnd);
        bit   fin;
        int   got;
        logic e_last, e_layer;
        logic [3:0] pat;
        win_t w;
        pat = 4'b1001; fin = 1'b0; got = 0; sel3 = 1'b0;
        build_q();
        win_ready = 1'b1; start = 1'b1;
        for (int k = 0; k < 400 && !fin; k++) begin
            @(negedge clk);
            if (o_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL bp_extra_window rnd=%0d: got b%0d(%0d,%0d) required none",
                             rnd, o_bank, o_row, o_col);
                end else begin
                    w = exp_q[0];
                    e_last  = (w.r == OH - 1 && w.c == OW - 1);
                    e_layer = e_last && (w.b == NB - 1);
                    if ({o_bank, o_row, o_col, o_last, o_layer} !==
                        {2'(w.b), 5'(w.r), 5'(w.c), e_last, e_layer}) begin
                        failures++;
                        $display("FAIL bp_window rnd=%0d: got b%0d(%0d,%0d) l%b/%b required b%0d(%0d,%0d) l%b/%b",
                                 rnd, o_bank, o_row, o_col, o_last, o_layer, w.b, w.r, w.c, e_last, e_layer);
                    end
                    if (win_ready) begin
                        void'(exp_q.pop_front());
                        got++;
                    end
                end
            end
            if (o_done) begin
                fin = 1'b1;
                checks++;
                if (got != NB * NWIN || exp_q.size() != 0) begin
                    failures++;
                    $display("FAIL bp_count rnd=%0d: got %0d windows required %0d", rnd, got, NB * NWIN);
                end
            end
            @(posedge clk); #1;
            start = 1'b0;
            win_ready = rnd ? 1'($urandom_range(0, 1)) : pat[(k + 1) % 4];
        end
        checks++;
        if (!fin) begin
            failures++;
            $display("FAIL bp_timeout rnd=%0d: got no done required done", rnd);
        end
        win_ready = 1'b1;
    endtask

    task automatic test_abort();
        bit dseen, found;
        sel3 = 1'b0; win_ready = 1'b1; abort = 1'b0; start = 1'b1; dseen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 9) begin
                checks++;
                if ({o_busy, o_valid, o_done, o_rom, o_last, o_layer, o_row, o_col, o_bank, o_bsel} !== '0) begin
                    failures++;
                    $display("FAIL abort_idle: got %b/%h/%h required all zero",
                             {o_busy, o_valid, o_done, o_rom, o_last, o_layer}, {o_row, o_col}, {o_bank, o_bsel});
                end
            end
            if (c >= 8 && o_done) dseen = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            abort = (c + 1 == 8);
        end
        checks++;
        if (dseen) begin
            failures++;
            $display("FAIL abort_no_done: got done=1 required 0");
        end
        start = 1'b1; found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (o_valid) begin
                found = 1'b1;
                checks++;
                if ({o_bank, o_row, o_col} !== 12'd0) begin
                    failures++;
                    $display("FAIL abort_restart: got b%0d(%0d,%0d) required b0(0,0)", o_bank, o_row, o_col);
                end
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL abort_restart_timeout: got no window required b0(0,0)");
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
    endtask

    task automatic test_reset_mid();
        sel3 = 1'b0; win_ready = 1'b1; start = 1'b1;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (c == 17) begin
                checks++;
                if ({o_busy, o_valid, o_done, o_rom, o_last, o_layer, o_row, o_col, o_bank, o_bsel} !== '0) begin
                    failures++;
                    $display("FAIL rst_mid: got %b/%h/%h required all zero",
                             {o_busy, o_valid, o_done, o_rom, o_last, o_layer}, {o_row, o_col}, {o_bank, o_bsel});
                end
            end
            @(posedge clk); #1;
            start = 1'b0;
            rst = (c + 1 == 16);
        end
        rst = 1'b0;
        start = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            checks++;
            if (o_done !== (c == 23)) begin
                failures++;
                $display("FAIL start_ignored cyc %0d: got done=%b required %b", c, o_done, (c == 23));
            end
            @(posedge clk); #1;
            start = (c + 1 == 10);
        end
    endtask

    initial begin
        test_reset();
        test_timing(1, 1'b0);
        test_backpressure(1'b0);
        test_backpressure(1'b1);
        test_timing(3, 1'b1);
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
